// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen -- program-counter generator for the multi-cycle RV32/RV64 core.
//
// Owns the architectural PC and issues instruction-fetch requests with a
// valid/ready handshake. On commit it resolves the next PC from branch flags,
// JAL/JALR, MRET or the sequential step. It also handles traps, WFI sleep,
// misaligned-target detection and the retired-instruction counter.
//
// Optional feature macro: PCGEN_RVC_EN
//   Defined   : adds input is_rvc. The sequential step is 2 for compressed
//               instructions and 4 otherwise. Only T[0] is checked for
//               misalignment.
//   Undefined : the step is always 4 and T[1:0] is checked.
//
// Ports:
//   CLK, RST                   clock and synchronous active-high reset
//   fetch_valid/ready/pc       fetch request handshake (fetch_pc == pc)
//   pc                         address of the current instruction
//   commit                     current instruction completes this cycle
//   br_valid, br_funct3,
//   br_eq, br_lt, br_ltu       conditional-branch decode and compare flags
//   jal, jalr, jalr_base, imm  jump decode, JALR base and immediate
//   trap, trap_vec             trap request and trap target
//   mret, mepc                 MRET decode and return target
//   wfi, irq_pending           WFI decode and pending-interrupt wake-up
//   is_rvc                     compressed instruction (PCGEN_RVC_EN only)
//   i_misaligned, illegal_br   combinational commit-time fault flags
//   halted                     core is sleeping in WFI
//   instret                    retired-instruction counter
// -----------------------------------------------------------------------------
module pc_gen #(
    parameter int              XLEN    = 32,
    parameter logic [XLEN-1:0] RST_VEC = {XLEN{1'b0}},
    parameter int              CNT_W   = 64
) (
    input  logic             CLK,
    input  logic             RST,
    output logic             fetch_valid,
    input  logic             fetch_ready,
    output logic [XLEN-1:0]  fetch_pc,
    output logic [XLEN-1:0]  pc,
    input  logic             commit,
    input  logic             br_valid,
    input  logic [2:0]       br_funct3,
    input  logic             br_eq,
    input  logic             br_lt,
    input  logic             br_ltu,
    input  logic             jal,
    input  logic             jalr,
    input  logic [XLEN-1:0]  jalr_base,
    input  logic [XLEN-1:0]  imm,
    input  logic             trap,
    input  logic [XLEN-1:0]  trap_vec,
    input  logic             mret,
    input  logic [XLEN-1:0]  mepc,
    input  logic             wfi,
    input  logic             irq_pending,
`ifdef PCGEN_RVC_EN
    input  logic             is_rvc,
`endif
    output logic             i_misaligned,
    output logic             illegal_br,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_SLEEP = 2'd3
    } state_t;

    localparam logic [XLEN-1:0]  STEP4     = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0]  JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              halted_q, halted_d;

    logic [XLEN-1:0]   step_s;
    logic [XLEN-1:0]   seq_pc_s;
    logic [XLEN-1:0]   target_s;
    logic              br_taken_s;
    logic              commit_s;
    logic              misaligned_s;

    // Alignment rule for a committed target; only the low PC bits matter.
    function automatic logic target_misaligned(input logic [1:0] low);
`ifdef PCGEN_RVC_EN
        return low[0];
`else
        return (low != 2'b00);
`endif
    endfunction

    // Sequential step size for the instruction currently executing.
    always_comb begin
`ifdef PCGEN_RVC_EN
        if (is_rvc) begin
            step_s = {{(XLEN-2){1'b0}}, 2'b10};
        end else begin
            step_s = STEP4;
        end
`else
        step_s = STEP4;
`endif
    end

    // Conditional-branch outcome; the reserved funct3 codes are never taken.
    always_comb begin
        case (br_funct3)
            3'b000:  br_taken_s = br_eq;
            3'b001:  br_taken_s = !br_eq;
            3'b100:  br_taken_s = br_lt;
            3'b101:  br_taken_s = !br_lt;
            3'b110:  br_taken_s = br_ltu;
            3'b111:  br_taken_s = !br_ltu;
            default: br_taken_s = 1'b0;
        endcase
    end

    // Commit target, in priority order mret > jalr > jal > branch > sequential.
    always_comb begin
        seq_pc_s = pc_q + step_s;
        if (mret) begin
            target_s = mepc;
        end else if (jalr) begin
            target_s = (jalr_base + imm) & JALR_MASK;
        end else if (jal) begin
            target_s = pc_q + imm;
        end else if (br_valid && br_taken_s) begin
            target_s = pc_q + imm;
        end else begin
            target_s = seq_pc_s;
        end
    end

    assign commit_s     = (state_q == ST_EXEC) && commit;
    assign misaligned_s = target_misaligned(target_s[1:0]);
    assign i_misaligned = commit_s && misaligned_s;
    assign illegal_br   = commit_s && br_valid && (br_funct3[2:1] == 2'b01);

    // Next-state logic for the PC, the FSM state and the retired-instruction count.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        case (state_q)
            ST_BOOT: begin
                // A trap is ignored while booting.
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (trap) begin
                    pc_d    = trap_vec;
                    state_d = ST_FETCH;
                end else if (fetch_valid_q && fetch_ready) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (trap) begin
                    pc_d    = trap_vec;
                    state_d = ST_FETCH;
                end else if (commit && !misaligned_s) begin
                    pc_d      = target_s;
                    instret_d = instret_q + CNT_ONE;
                    state_d   = (wfi && !irq_pending) ? ST_SLEEP : ST_FETCH;
                end else begin
                    // A misaligned target holds here until the core raises a trap.
                    state_d = ST_EXEC;
                end
            end
            ST_SLEEP: begin
                if (trap) begin
                    pc_d    = trap_vec;
                    state_d = ST_FETCH;
                end else if (irq_pending) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_SLEEP;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Registered status outputs. A trap taken in FETCH aborts the outstanding
    // request, so fetch_valid stays low for one cycle before re-requesting.
    always_comb begin
        fetch_valid_d = (state_d == ST_FETCH) && !(trap && (state_q == ST_FETCH));
        halted_d      = (state_d == ST_SLEEP);
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_BOOT;
            pc_q          <= RST_VEC;
            instret_q     <= {CNT_W{1'b0}};
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instret_q     <= instret_d;
            fetch_valid_q <= fetch_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign pc          = pc_q;
    assign fetch_pc    = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign halted      = halted_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen -- directed self-checking bench for pc_gen (XLEN=32, RST_VEC=0x100).
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pc_gen;

    logic        CLK;
    logic        RST;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [31:0] pc;
    logic        commit;
    logic        br_valid;
    logic [2:0]  br_funct3;
    logic        br_eq;
    logic        br_lt;
    logic        br_ltu;
    logic        jal;
    logic        jalr;
    logic [31:0] jalr_base;
    logic [31:0] imm;
    logic        trap;
    logic [31:0] trap_vec;
    logic        mret;
    logic [31:0] mepc;
    logic        wfi;
    logic        irq_pending;
`ifdef PCGEN_RVC_EN
    logic        is_rvc;
`endif
    logic        i_misaligned;
    logic        illegal_br;
    logic        halted;
    logic [63:0] instret;

    int          checks;
    int          errors;
    logic [31:0] exp_pc;
    logic [63:0] exp_ir;

    pc_gen #(
        .XLEN    (32),
        .RST_VEC (32'h0000_0100),
        .CNT_W   (64)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .fetch_pc     (fetch_pc),
        .pc           (pc),
        .commit       (commit),
        .br_valid     (br_valid),
        .br_funct3    (br_funct3),
        .br_eq        (br_eq),
        .br_lt        (br_lt),
        .br_ltu       (br_ltu),
        .jal          (jal),
        .jalr         (jalr),
        .jalr_base    (jalr_base),
        .imm          (imm),
        .trap         (trap),
        .trap_vec     (trap_vec),
        .mret         (mret),
        .mepc         (mepc),
        .wfi          (wfi),
        .irq_pending  (irq_pending),
`ifdef PCGEN_RVC_EN
        .is_rvc       (is_rvc),
`endif
        .i_misaligned (i_misaligned),
        .illegal_br   (illegal_br),
        .halted       (halted),
        .instret      (instret)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        commit    = 1'b0;
        br_valid  = 1'b0;
        br_funct3 = 3'b000;
        br_eq     = 1'b0;
        br_lt     = 1'b0;
        br_ltu    = 1'b0;
        jal       = 1'b0;
        jalr      = 1'b0;
        jalr_base = 32'h0;
        imm       = 32'h0;
        trap      = 1'b0;
        trap_vec  = 32'h0;
        mret      = 1'b0;
        mepc      = 32'h0;
        wfi       = 1'b0;
`ifdef PCGEN_RVC_EN
        is_rvc    = 1'b0;
`endif
    endtask

    // Waits (bounded) for a fetch request, then accepts it.
    task automatic do_fetch();
        int n;
        n = 0;
        while (!fetch_valid && n < 4) begin
            tick();
            n++;
        end
        chk("fetch_wait", {63'd0, fetch_valid}, 64'd1);
        chk("fetch_addr", {32'd0, fetch_pc}, {32'd0, exp_pc});
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        chk("fetch_accept", {63'd0, fetch_valid}, 64'd0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        RST         = 1'b1;
        fetch_ready = 1'b0;
        irq_pending = 1'b0;
        clear_inputs();
        exp_pc = 32'h100;
        exp_ir = 64'd0;

        // Reset state.
        tick();
        tick();
        chk("rst_pc", {32'd0, pc}, 64'h100);
        chk("rst_fv", {63'd0, fetch_valid}, 64'd0);
        chk("rst_halted", {63'd0, halted}, 64'd0);
        chk("rst_instret", instret, 64'd0);

        // One BOOT cycle, then FETCH.
        RST = 1'b0;
        chk("boot_fv", {63'd0, fetch_valid}, 64'd0);
        chk("boot_halted", {63'd0, halted}, 64'd0);
        tick();
        chk("fetch_fv", {63'd0, fetch_valid}, 64'd1);
        chk("fetch_pc", {32'd0, fetch_pc}, 64'h100);

        // Stall: request stays up and stable.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_fv", {63'd0, fetch_valid}, 64'd1);
            chk("stall_pc", {32'd0, fetch_pc}, 64'h100);
        end
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        chk("accept_fv", {63'd0, fetch_valid}, 64'd0);

        // BEQ taken: 0x100 + 0x20.
        br_valid = 1'b1; br_funct3 = 3'b000; br_eq = 1'b1; imm = 32'h20; commit = 1'b1;
        #1;
        chk("beq_mis", {63'd0, i_misaligned}, 64'd0);
        chk("beq_ill", {63'd0, illegal_br}, 64'd0);
        tick();
        clear_inputs();
        exp_pc = 32'h120; exp_ir = 64'd1;
        chk("beq_pc", {32'd0, pc}, {32'd0, exp_pc});
        chk("beq_instret", instret, exp_ir);
        chk("beq_fv", {63'd0, fetch_valid}, 64'd1);

        // Commit during FETCH is ignored.
        commit = 1'b1; jal = 1'b1; imm = 32'h40;
        tick();
        clear_inputs();
        chk("fetch_commit_pc", {32'd0, pc}, {32'd0, exp_pc});
        chk("fetch_commit_ir", instret, exp_ir);

        // BGEU with br_ltu=1: not taken, sequential.
        do_fetch();
        br_valid = 1'b1; br_funct3 = 3'b111; br_ltu = 1'b1; imm = 32'h40; commit = 1'b1;
        tick();
        clear_inputs();
        exp_pc = 32'h124; exp_ir = 64'd2;
        chk("bgeu_pc", {32'd0, pc}, {32'd0, exp_pc});
        chk("bgeu_instret", instret, exp_ir);

        // JALR to 0x203 -> 0x202.
        do_fetch();
        jalr = 1'b1; jalr_base = 32'h203; imm = 32'h0; commit = 1'b1;
        #1;
`ifdef PCGEN_RVC_EN
        chk("jalr_mis", {63'd0, i_misaligned}, 64'd0);
        tick();
        clear_inputs();
        exp_pc = 32'h202; exp_ir = exp_ir + 64'd1;
`else
        chk("jalr_mis", {63'd0, i_misaligned}, 64'd1);
        tick();
        clear_inputs();
        chk("jalr_hold_fv", {63'd0, fetch_valid}, 64'd0);
`endif
        chk("jalr_pc", {32'd0, pc}, {32'd0, exp_pc});
        chk("jalr_instret", instret, exp_ir);

        // Trap to 0x80, instret unchanged.
        trap = 1'b1; trap_vec = 32'h80;
        tick();
        clear_inputs();
        exp_pc = 32'h80;
        chk("trap_pc", {32'd0, pc}, {32'd0, exp_pc});
        chk("trap_instret", instret, exp_ir);

        // BNE taken to 0x86.
        do_fetch();
        br_valid = 1'b1; br_funct3 = 3'b001; br_eq = 1'b0; imm = 32'h6; commit = 1'b1;
        #1;
`ifdef PCGEN_RVC_EN
        chk("bne_mis", {63'd0, i_misaligned}, 64'd0);
        tick();
        clear_inputs();
        exp_pc = 32'h86; exp_ir = exp_ir + 64'd1;
        chk("bne_pc", {32'd0, pc}, {32'd0, exp_pc});
        do_fetch();
`else
        chk("bne_mis", {63'd0, i_misaligned}, 64'd1);
        tick();
        clear_inputs();
        chk("bne_pc", {32'd0, pc}, {32'd0, exp_pc});
`endif

        // Reserved funct3 010: illegal_br, sequential.
        br_valid = 1'b1; br_funct3 = 3'b010; br_eq = 1'b1; imm = 32'h10; commit = 1'b1;
        #1;
        chk("ill_flag", {63'd0, illegal_br}, 64'd1);
        chk("ill_mis", {63'd0, i_misaligned}, 64'd0);
        tick();
        clear_inputs();
        exp_pc = exp_pc + 32'd4; exp_ir = exp_ir + 64'd1;
        chk("ill_pc", {32'd0, pc}, {32'd0, exp_pc});
        chk("ill_instret", instret, exp_ir);

        // Trap while a fetch is offered and accepted: request aborted.
        fetch_ready = 1'b1; trap = 1'b1; trap_vec = 32'h300;
        tick();
        clear_inputs();
        exp_pc = 32'h300;
        chk("abort_pc", {32'd0, pc}, {32'd0, exp_pc});
        chk("abort_fv", {63'd0, fetch_valid}, 64'd0);
        tick();
        fetch_ready = 1'b0;
        chk("abort_refv", {63'd0, fetch_valid}, 64'd1);
        chk("abort_repc", {32'd0, fetch_pc}, {32'd0, exp_pc});

        // WFI with no interrupt: sleep, then wake at 0x304.
        do_fetch();
        wfi = 1'b1; commit = 1'b1;
        tick();
        clear_inputs();
        exp_pc = 32'h304; exp_ir = exp_ir + 64'd1;
        chk("wfi_halted", {63'd0, halted}, 64'd1);
        chk("wfi_fv", {63'd0, fetch_valid}, 64'd0);
        chk("wfi_pc", {32'd0, pc}, {32'd0, exp_pc});
        tick();
        chk("sleep_halted", {63'd0, halted}, 64'd1);
        irq_pending = 1'b1;
        tick();
        irq_pending = 1'b0;
        chk("wake_halted", {63'd0, halted}, 64'd0);
        chk("wake_fv", {63'd0, fetch_valid}, 64'd1);
        chk("wake_pc", {32'd0, fetch_pc}, {32'd0, exp_pc});

        // Trap beats simultaneous mret+commit.
        do_fetch();
        trap = 1'b1; trap_vec = 32'h80; mret = 1'b1; mepc = 32'h400; commit = 1'b1;
        tick();
        clear_inputs();
        exp_pc = 32'h80;
        chk("trap_mret_pc", {32'd0, pc}, {32'd0, exp_pc});
        chk("trap_mret_ir", instret, exp_ir);

        // Plain mret.
        do_fetch();
        mret = 1'b1; mepc = 32'h400; commit = 1'b1;
        tick();
        clear_inputs();
        exp_pc = 32'h400; exp_ir = exp_ir + 64'd1;
        chk("mret_pc", {32'd0, pc}, {32'd0, exp_pc});
        chk("mret_instret", instret, exp_ir);

        // JAL backwards by 0x10.
        do_fetch();
        jal = 1'b1; imm = 32'hFFFF_FFF0; commit = 1'b1;
        tick();
        clear_inputs();
        exp_pc = 32'h3F0; exp_ir = exp_ir + 64'd1;
        chk("jal_pc", {32'd0, pc}, {32'd0, exp_pc});

        // Sequential commit wraps 0xFFFFFFFC -> 0.
        trap = 1'b1; trap_vec = 32'hFFFF_FFFC;
        tick();
        clear_inputs();
        exp_pc = 32'hFFFF_FFFC;
        do_fetch();
        commit = 1'b1;
        tick();
        clear_inputs();
        exp_pc = 32'h0; exp_ir = exp_ir + 64'd1;
        chk("wrap_pc", {32'd0, pc}, {32'd0, exp_pc});
        chk("wrap_instret", instret, exp_ir);

        // BLT taken to 0x10.
        do_fetch();
        br_valid = 1'b1; br_funct3 = 3'b100; br_lt = 1'b1; imm = 32'h10; commit = 1'b1;
        tick();
        clear_inputs();
        exp_pc = 32'h10; exp_ir = exp_ir + 64'd1;
        chk("blt_pc", {32'd0, pc}, {32'd0, exp_pc});
        chk("blt_instret", instret, exp_ir);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
